// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block.
//   sw_state_t   : FSM state encoding as seen on the state output
//                  (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//   DIR_UP/DOWN  : dswitch / sw_dir polarity
//   bcd_is_zero  : true when all four counter digits read zero
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic bcd_is_zero(
        input logic [3:0] d_min,
        input logic [3:0] d_sec_msd,
        input logic [3:0] d_sec_lsd,
        input logic [3:0] d_tenths
    );
        return (d_min | d_sec_msd | d_sec_lsd | d_tenths) == 4'd0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus debouncer for one raw, asynchronous input.
// The raw level goes through a two-flop synchroniser; the synchronised
// value is accepted as the new debounced level once it has differed from
// the current level for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw input
//   level  out  debounced level (RESET_VAL after reset)
//   rise   out  one-clock pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500_000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg  <= RESET_VAL;
            sync_reg  <= RESET_VAL;
            cnt_reg   <= '0;
            level_reg <= RESET_VAL;
            rise_reg  <= 1'b0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            rise_reg <= 1'b0;
            if (sync_reg == level_reg) begin
                // Any bounce back to the accepted level restarts the wait.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= sync_reg;
                rise_reg  <= sync_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control stage for the min/sec/tenths BCD counter chain.
// Divides clk into the 50% duty tick that clocks the chain, debounces the
// start/stop and clear buttons and the direction switch, and runs the
// IDLE/RUN/PAUSE/DONE FSM that drives the chain's enable, clr and dswitch.
// The chain's digits are read back so that a countdown stops at 0:00:0.
//
// All control outputs change only at the update point (UP): the clock in
// which tick falls. They are therefore stable at every tick rising edge.
//
// Optional feature: define STOPWATCH_ALARM_EN to build the alarm counter
// (alarm held high for ALARM_TICKS tick periods after entering DONE).
// Without it, alarm is tied low and ALARM_TICKS does not exist.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   btn_ss, btn_clr, sw_dir      raw buttons / direction switch (1 = up)
//   min, sec_msd, sec_lsd, tenths  BCD digits read back from the chain
//   tick                         divided clock to the chain
//   enable, clr, dswitch         chain control
//   state                        FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//   alarm                        countdown-complete indicator
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 500_000
`ifdef STOPWATCH_ALARM_EN
    ,
    parameter int ALARM_TICKS     = 30
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       sw_dir,
    input  logic [3:0] min,
    input  logic [3:0] sec_msd,
    input  logic [3:0] sec_lsd,
    input  logic [3:0] tenths,
    output logic       tick,
    output logic       enable,
    output logic       clr,
    output logic       dswitch,
    output logic [1:0] state,
    output logic       alarm
);

    // ------------------------------------------------------------------
    // Tick divider: toggles tick every HALF clocks.
    // ------------------------------------------------------------------
    localparam int HALF  = CLK_HZ / (2 * TICK_HZ);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick_reg;
    logic             up;

    // Terminal count while tick is high is the 1 -> 0 transition.
    assign up = (div_cnt_reg == DIV_LAST) && tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            tick_reg    <= ~tick_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Input conditioning. Bit 0 = start/stop, 1 = clear, 2 = direction.
    // The direction switch resets to "up" to match dswitch.
    // ------------------------------------------------------------------
    localparam logic [2:0] DB_RESET = {DIR_UP, 1'b0, 1'b0};

    logic [2:0] raw_in;
    logic [2:0] db_level;
    logic [2:0] db_rise;

    assign raw_in = {sw_dir, btn_clr, btn_ss};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (DB_RESET[gi])
            ) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_in[gi]),
                .level (db_level[gi]),
                .rise  (db_rise[gi])
            );
        end
    endgenerate

    // Buttons only matter on their press edge, the switch only by level.
    logic db_unused;
    assign db_unused = ^{db_level[1:0], db_rise[2]};

    logic dir_db;
    assign dir_db = db_level[2];

    // ------------------------------------------------------------------
    // Pending button events: any number of presses between two UPs
    // collapse into one event. A press landing exactly on the UP is
    // included in that UP rather than lost.
    // ------------------------------------------------------------------
    logic ss_pend_reg;
    logic clr_pend_reg;
    logic ss_event;
    logic clr_event;

    assign ss_event  = ss_pend_reg  | db_rise[0];
    assign clr_event = clr_pend_reg | db_rise[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_pend_reg  <= 1'b0;
            clr_pend_reg <= 1'b0;
        end else if (up) begin
            ss_pend_reg  <= 1'b0;
            clr_pend_reg <= 1'b0;
        end else begin
            ss_pend_reg  <= ss_event;
            clr_pend_reg <= clr_event;
        end
    end

    // ------------------------------------------------------------------
    // FSM, evaluated only at UPs. Priority: clear > zero check > start/stop.
    // ------------------------------------------------------------------
    sw_state_t state_reg;
    logic      enable_reg;
    logic      clr_reg;
    logic      dswitch_reg;
    logic      zero;
    logic      done_entry;

    assign zero = bcd_is_zero(min, sec_msd, sec_lsd, tenths);
    assign done_entry = up && !clr_event && (state_reg == ST_RUN) &&
                        (dswitch_reg == DIR_DOWN) && zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            enable_reg  <= 1'b0;
            clr_reg     <= 1'b0;
            dswitch_reg <= DIR_UP;
        end else if (up) begin
            // Direction may only change while the chain is not counting.
            if ((state_reg == ST_IDLE) || (state_reg == ST_PAUSE)) begin
                dswitch_reg <= dir_db;
            end
            if (clr_event) begin
                state_reg  <= ST_IDLE;
                clr_reg    <= 1'b1;
                enable_reg <= 1'b0;
            end else begin
                clr_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE, ST_PAUSE: begin
                        // Refuse to start a countdown that is already at zero,
                        // otherwise the first tick would wrap to 9:59:9.
                        if (ss_event && !((dir_db == DIR_DOWN) && zero)) begin
                            state_reg  <= ST_RUN;
                            enable_reg <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (done_entry) begin
                            state_reg  <= ST_DONE;
                            enable_reg <= 1'b0;
                        end else if (ss_event) begin
                            state_reg  <= ST_PAUSE;
                            enable_reg <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        enable_reg <= 1'b0;
                    end
                    default: begin
                        state_reg  <= ST_IDLE;
                        enable_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
`ifdef STOPWATCH_ALARM_EN
    localparam int ALM_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_TICKS - 1);

    logic [ALM_W-1:0] alarm_cnt_reg;
    logic             alarm_reg;

    // The entry UP counts as the first of ALARM_TICKS periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt_reg <= '0;
            alarm_reg     <= 1'b0;
        end else if (up) begin
            if (clr_event) begin
                alarm_reg     <= 1'b0;
                alarm_cnt_reg <= '0;
            end else if (done_entry) begin
                alarm_reg     <= 1'b1;
                alarm_cnt_reg <= ALM_LAST;
            end else if (alarm_reg) begin
                if (alarm_cnt_reg == '0) begin
                    alarm_reg <= 1'b0;
                end else begin
                    alarm_cnt_reg <= alarm_cnt_reg - 1'b1;
                end
            end
        end
    end

    assign alarm = alarm_reg;
`else
    assign alarm = 1'b0;
`endif

    assign tick    = tick_reg;
    assign enable  = enable_reg;
    assign clr     = clr_reg;
    assign dswitch = dswitch_reg;
    assign state   = state_reg;

endmodule
